bf_bus_responder: RTL and testbench
===================================

// Module: bf_bus_responder
// PURPOSE
//  Target end of the BF interpreter bus: decodes bus_op/addr/val_out from the BF core and serves program
//  memory, zero-initialised data memory and byte IO through handshaked in/out FIFOs. Drives the core's
//  enable to stall it during init, program load, empty-input reads and full-output writes.
// PARAMETERS
//  ADDR_WIDTH  15    bus address width (matches core)
//  BUS_WIDTH   8     bus data width
//  PROG_DEPTH  4096  program bytes; reads at addr >= PROG_DEPTH return 0 (halt)
//  DATA_DEPTH  4096  data cells, power of 2; data addr = bus_addr mod DATA_DEPTH
//  FIFO_DEPTH  4     entries in each IO FIFO, power of 2, >= 2
// PORTS
//  clock       in   1           single clock, all logic on posedge
//  reset_n     in   1           asynchronous, active-low reset
//  bus_op      in   BusOp       core bus operation
//  bus_addr    in   ADDR_WIDTH  core addr
//  bus_wdata   in   BUS_WIDTH   core val_out
//  bus_rdata   out  BUS_WIDTH   to core val_in; registered read data
//  cpu_enable  out  1           to core enable; 0 = core holds state
//  run         out  1           1 in RUN state
//  load_valid  in   1           program byte valid
//  load_ready  out  1           1 only in LOAD
//  load_data   in   BUS_WIDTH   program byte
//  load_last   in   1           marks final program byte
//  in_valid    in   1           input byte valid
//  in_ready    out  1           = !in_fifo_full
//  in_data     in   BUS_WIDTH   input byte
//  out_valid   out  1           = !out_fifo_empty
//  out_ready   in   1           consumer accepts out_data
//  out_data    out  BUS_WIDTH   head of out FIFO
// BEHAVIOUR
//  Reset: state=CLEAR, clr_ptr=0, prog_ptr=0, FIFOs empty; bus_rdata=0, cpu_enable=0, run=0,
//   load_ready=0, in_ready=1, out_valid=0, out_data=0. Reset mid-op aborts everything; program must reload.
//  FSM: CLEAR -> LOAD -> TERM -> RUN; RUN held until reset.
//   CLEAR: write 0 to data[clr_ptr] each cycle; after DATA_DEPTH cycles (ptr wraps to 0) -> LOAD.
//   LOAD: load_ready=1; on load_valid: prog[prog_ptr]=load_data if prog_ptr<PROG_DEPTH (else dropped),
//    prog_ptr++ saturating at PROG_DEPTH; with load_last -> TERM.
//   TERM: write 0x00 at prog[prog_ptr] if in range; 1 cycle -> RUN.
//  cpu_enable = run && !(bus_op==BusReadIo && in_empty) && !(bus_op==BusWriteIo && out_full).
//   Full/empty from current occupancy only; no same-cycle bypass.
//  Op accepted only when cpu_enable=1; in RUN, acceptance is the posedge where it is sampled:
//   BusReadProg: bus_rdata <= prog[addr] (0 if out of range)   BusReadData: bus_rdata <= data[addr]
//   BusWriteData: data[addr] <= bus_wdata                       BusReadIo: bus_rdata <= in head; pop
//   BusWriteIo: push bus_wdata into out FIFO                     BusNone/other: no effect
//  Read latency 1: data valid the cycle after acceptance; bus_rdata holds until next accepted read.
//  Write-then-read same address in consecutive cycles returns new value (no read-during-write hazard).
//  Stalled op: core repeats it until accepted; exactly one pop/push per accepted op.
//  In FIFO: push on in_valid&&in_ready, any state; simultaneous push+pop when not full: count unchanged.
//  Out FIFO: pop on out_valid&&out_ready; push+pop same cycle when full still stalls core that cycle.
//  FIFO pointers wrap mod FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
// TESTING
//  1 Reset, DATA_DEPTH=16: cpu_enable=0 for 16 CLEAR cycles; then ReadData any addr -> bus_rdata=0x00.
//  2 Load "+." with load_last on '.': prog[0..2]="+",".",0x00; run=1 exactly 1 cycle after last byte.
//  3 Core runs "+." with out_ready=1 -> out_valid pulse with out_data=0x01; core halts on 0x00.
//  4 ",." with in FIFO empty: cpu_enable=0 while ReadIo; push 0x41 -> next cycle rdata=0x41; out gets 0x41.
//  5 out_ready=0, program ".........": after FIFO_DEPTH pushes cpu_enable=0; out_ready=1 -> resumes, no loss/dup.
//  6 ReadProg addr=PROG_DEPTH+3 -> bus_rdata=0; WriteData addr=DATA_DEPTH+1 val 7 -> ReadData addr 1 = 7.

Source files
------------

// File: rtl/bf_bus_responder.sv
// bf_bus_responder: target end of the BF interpreter bus.
//   Serves program memory, zero-initialised data memory and byte IO
//   (handshaked in/out FIFOs) to the BF core. Stalls the core via cpu_enable
//   while data memory is cleared, while the program loads, while the core
//   reads from an empty input FIFO and while it writes to a full output FIFO.
// Ports:
//   clock, reset_n              single clock, async active-low reset
//   bus_op/bus_addr/bus_wdata   core bus request
//   bus_rdata                   registered read data to the core
//   cpu_enable, run             core enable and RUN-state flag
//   load_*                      program byte stream (valid/ready, last marks end)
//   in_*                        input byte stream into the in FIFO
//   out_*                       output byte stream from the out FIFO
//
// state    | meaning
// ST_CLEAR | zero one data cell per cycle until the pointer wraps
// ST_LOAD  | accept program bytes until load_last
// ST_TERM  | write the 0x00 terminator after the program
// ST_RUN   | serve core bus operations (held until reset)

package bf_bus_pkg;
    typedef enum logic [2:0] {
        BUS_NONE       = 3'd0,
        BUS_READ_PROG  = 3'd1,
        BUS_READ_DATA  = 3'd2,
        BUS_WRITE_DATA = 3'd3,
        BUS_READ_IO    = 3'd4,
        BUS_WRITE_IO   = 3'd5
    } bus_op_t;
endpackage

module bf_bus_responder
    import bf_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int BUS_WIDTH  = 8,
    parameter int PROG_DEPTH = 4096,
    parameter int DATA_DEPTH = 4096,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  bus_op_t               bus_op,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [BUS_WIDTH-1:0]  bus_wdata,
    output logic [BUS_WIDTH-1:0]  bus_rdata,
    output logic                  cpu_enable,
    output logic                  run,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [BUS_WIDTH-1:0]  load_data,
    input  logic                  load_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BUS_WIDTH-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BUS_WIDTH-1:0]  out_data
);
    localparam int PIW = $clog2(PROG_DEPTH);
    localparam int PPW = $clog2(PROG_DEPTH + 1);
    localparam int DIW = $clog2(DATA_DEPTH);
    localparam int FIW = $clog2(FIFO_DEPTH);
    localparam int FCW = FIW + 1;

    typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_TERM, ST_RUN} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DIW-1:0]       clr_ptr;
    logic [PPW-1:0]       prog_ptr;

    logic [BUS_WIDTH-1:0] prog_mem [PROG_DEPTH];
    logic [BUS_WIDTH-1:0] data_mem [DATA_DEPTH];

    logic [BUS_WIDTH-1:0] in_mem  [FIFO_DEPTH];
    logic [FIW-1:0]       in_wr;
    logic [FIW-1:0]       in_rd;
    logic [FCW-1:0]       in_cnt;
    logic [BUS_WIDTH-1:0] out_mem [FIFO_DEPTH];
    logic [FIW-1:0]       out_wr;
    logic [FIW-1:0]       out_rd;
    logic [FCW-1:0]       out_cnt;

    logic in_empty, in_full, out_empty, out_full;
    logic in_push, in_pop, out_push, out_pop;
    logic rd_prog, rd_data, wr_data;
    logic prog_in_range, ptr_in_range, load_take;
    logic prog_we;
    logic [BUS_WIDTH-1:0] prog_wdata;
    logic data_we;
    logic [DIW-1:0] data_waddr;
    logic [BUS_WIDTH-1:0] data_wdata;

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_CLEAR;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        run        = 1'b0;
        case (state)
            ST_CLEAR: if (clr_ptr == DIW'(DATA_DEPTH - 1)) state_nxt = ST_LOAD;
            ST_LOAD: begin
                load_ready = 1'b1;
                if (load_valid && load_last) state_nxt = ST_TERM;
            end
            ST_TERM:  state_nxt = ST_RUN;
            ST_RUN:   run = 1'b1;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    // ---------------- core handshake ----------------
    // Full/empty come from registered occupancy only, so a same-cycle
    // push into an empty in FIFO (or pop from a full out FIFO) still stalls.
    assign in_empty  = (in_cnt == '0);
    assign in_full   = (in_cnt == FCW'(FIFO_DEPTH));
    assign out_empty = (out_cnt == '0);
    assign out_full  = (out_cnt == FCW'(FIFO_DEPTH));

    assign cpu_enable = run
                        && !((bus_op == BUS_READ_IO)  && in_empty)
                        && !((bus_op == BUS_WRITE_IO) && out_full);

    assign rd_prog  = cpu_enable && (bus_op == BUS_READ_PROG);
    assign rd_data  = cpu_enable && (bus_op == BUS_READ_DATA);
    assign wr_data  = cpu_enable && (bus_op == BUS_WRITE_DATA);
    assign in_pop   = cpu_enable && (bus_op == BUS_READ_IO);
    assign out_push = cpu_enable && (bus_op == BUS_WRITE_IO);

    assign prog_in_range = (bus_addr < ADDR_WIDTH'(PROG_DEPTH));

    // ---------------- program memory ----------------
    assign ptr_in_range = (prog_ptr < PPW'(PROG_DEPTH));
    assign load_take    = (state == ST_LOAD) && load_valid;
    assign prog_we      = ptr_in_range && (load_take || (state == ST_TERM));
    assign prog_wdata   = (state == ST_TERM) ? '0 : load_data;

    always_ff @(posedge clock) begin
        if (prog_we) prog_mem[prog_ptr[PIW-1:0]] <= prog_wdata;
    end

    // ---------------- data memory ----------------
    assign data_we    = (state == ST_CLEAR) || wr_data;
    assign data_waddr = (state == ST_CLEAR) ? clr_ptr : bus_addr[DIW-1:0];
    assign data_wdata = (state == ST_CLEAR) ? '0 : bus_wdata;

    always_ff @(posedge clock) begin
        if (data_we) data_mem[data_waddr] <= data_wdata;
    end

    // ---------------- pointers and read data ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clr_ptr   <= '0;
            prog_ptr  <= '0;
            bus_rdata <= '0;
        end else begin
            if (state == ST_CLEAR) clr_ptr <= clr_ptr + 1'b1;
            // Pointer saturates at PROG_DEPTH; surplus bytes are dropped.
            if (load_take && ptr_in_range) prog_ptr <= prog_ptr + 1'b1;
            if (rd_prog)
                bus_rdata <= prog_in_range ? prog_mem[bus_addr[PIW-1:0]] : '0;
            else if (rd_data)
                bus_rdata <= data_mem[bus_addr[DIW-1:0]];
            else if (in_pop)
                bus_rdata <= in_mem[in_rd];
        end
    end

    // ---------------- input FIFO ----------------
    assign in_ready = !in_full;
    assign in_push  = in_valid && !in_full;

    always_ff @(posedge clock) begin
        if (in_push) in_mem[in_wr] <= in_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_wr  <= '0;
            in_rd  <= '0;
            in_cnt <= '0;
        end else begin
            if (in_push) in_wr <= in_wr + 1'b1;
            if (in_pop)  in_rd <= in_rd + 1'b1;
            case ({in_push, in_pop})
                2'b10:   in_cnt <= in_cnt + 1'b1;
                2'b01:   in_cnt <= in_cnt - 1'b1;
                default: in_cnt <= in_cnt;
            endcase
        end
    end

    // ---------------- output FIFO ----------------
    assign out_valid = !out_empty;
    assign out_pop   = out_valid && out_ready;
    // Storage is not reset; mask the head so out_data reads 0 when empty.
    assign out_data  = out_empty ? '0 : out_mem[out_rd];

    always_ff @(posedge clock) begin
        if (out_push) out_mem[out_wr] <= bus_wdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_wr  <= '0;
            out_rd  <= '0;
            out_cnt <= '0;
        end else begin
            if (out_push) out_wr <= out_wr + 1'b1;
            if (out_pop)  out_rd <= out_rd + 1'b1;
            case ({out_push, out_pop})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_bf_bus_responder.sv
// Testbench for bf_bus_responder: plays the role of the BF core and of the
// load/in/out stream partners. Read results and output bytes are checked
// through expectation queues.
module tb_bf_bus_responder;
    import bf_bus_pkg::*;

    localparam int PD = 16;
    localparam int DD = 16;
    localparam int FD = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    bus_op_t     bus_op = BUS_NONE;
    logic [14:0] bus_addr = '0;
    logic [7:0]  bus_wdata = '0;
    logic [7:0]  bus_rdata;
    logic        cpu_enable, run;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [7:0]  load_data = '0;
    logic        load_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;

    bf_bus_responder #(
        .ADDR_WIDTH(15), .BUS_WIDTH(8), .PROG_DEPTH(PD), .DATA_DEPTH(DD), .FIFO_DEPTH(FD)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .bus_op(bus_op), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .cpu_enable(cpu_enable), .run(run),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        bus_op_t     op;
        logic [14:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int out_seen = 0;
    logic [7:0] rq[$];
    logic [7:0] oq[$];
    logic [7:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    // Output stream scoreboard: a byte is consumed on the edge after this sample.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (oq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out_unexpected: got=0x%0h want=none", out_data);
            end else begin
                mon_exp = oq.pop_front();
                check("out_data", {24'h0, out_data}, {24'h0, mon_exp});
                out_seen++;
            end
        end
    end

    // Issue one core op, repeating it while stalled; reads are checked one cycle later.
    task automatic do_op(input bus_op_t op, input logic [14:0] a, input logic [7:0] w,
                         input logic [7:0] exp);
        int n = 0;
        bus_op = op;
        bus_addr = a;
        bus_wdata = w;
        #1;
        while (!cpu_enable && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!cpu_enable) begin
            checks++;
            failures++;
            $display("FAIL stall_timeout: op=%0d cpu_enable=0 want=1", op);
            bus_op = BUS_NONE;
            return;
        end
        if (op == BUS_READ_PROG || op == BUS_READ_DATA || op == BUS_READ_IO) rq.push_back(exp);
        if (op == BUS_WRITE_IO) oq.push_back(w);
        @(posedge clock);
        #1;
        bus_op = BUS_NONE;
        if (rq.size() > 0)
            check($sformatf("rdata op%0d addr%0d", op, a), {24'h0, bus_rdata}, {24'h0, rq.pop_front()});
    endtask

    task automatic load_byte(input logic [7:0] d, input bit last);
        int n = 0;
        load_valid = 1'b1;
        load_data = d;
        load_last = last;
        #1;
        while (!load_ready && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("load_ready_wait", {31'h0, load_ready}, 32'h1);
        @(posedge clock);
        #1;
        load_valid = 1'b0;
        load_last = 1'b0;
    endtask

    // Reset, release, and count CLEAR cycles until LOAD is reached.
    task automatic do_reset(input bit check_reset_state);
        int n = 0;
        bit en_seen = 1'b0;
        bus_op = BUS_NONE;
        in_valid = 1'b0;
        load_valid = 1'b0;
        out_ready = 1'b0;
        reset_n = 1'b0;
        rq.delete();
        oq.delete();
        #3;
        if (check_reset_state) begin
            check("rst_rdata",      {24'h0, bus_rdata}, 32'h0);
            check("rst_cpu_enable", {31'h0, cpu_enable}, 32'h0);
            check("rst_run",        {31'h0, run}, 32'h0);
            check("rst_load_ready", {31'h0, load_ready}, 32'h0);
            check("rst_in_ready",   {31'h0, in_ready}, 32'h1);
            check("rst_out_valid",  {31'h0, out_valid}, 32'h0);
            check("rst_out_data",   {24'h0, out_data}, 32'h0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        while (!load_ready && n < 100) begin
            @(posedge clock);
            #1;
            n++;
            if (cpu_enable) en_seen = 1'b1;
        end
        check("clear_cycles", n, DD);
        check("clear_enable", {31'h0, en_seen}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v1[9];
        vec_t v2[8];
        int n;
        int base;

        v1[0] = '{BUS_READ_DATA,  15'd3,       8'h00, 8'h00};
        v1[1] = '{BUS_WRITE_DATA, 15'd5,       8'h99, 8'h00};
        v1[2] = '{BUS_READ_DATA,  15'd5,       8'h00, 8'h99};
        v1[3] = '{BUS_WRITE_DATA, 15'(DD + 1), 8'h07, 8'h00};
        v1[4] = '{BUS_READ_DATA,  15'd1,       8'h00, 8'h07};
        v1[5] = '{BUS_READ_PROG,  15'(PD + 1), 8'h00, 8'h00};
        v1[6] = '{BUS_READ_PROG,  15'd1,       8'h00, 8'h22};
        v1[7] = '{BUS_READ_PROG,  15'd2,       8'h00, 8'h33};
        v1[8] = '{BUS_READ_PROG,  15'd3,       8'h00, 8'h00};

        // Core executing "+." : fetch, inc cell, fetch, output, fetch terminator.
        v2[0] = '{BUS_READ_DATA,  15'd5, 8'h00, 8'h00};
        v2[1] = '{BUS_READ_PROG,  15'd0, 8'h00, 8'h2B};
        v2[2] = '{BUS_READ_DATA,  15'd0, 8'h00, 8'h00};
        v2[3] = '{BUS_WRITE_DATA, 15'd0, 8'h01, 8'h00};
        v2[4] = '{BUS_READ_PROG,  15'd1, 8'h00, 8'h2E};
        v2[5] = '{BUS_READ_DATA,  15'd0, 8'h00, 8'h01};
        v2[6] = '{BUS_WRITE_IO,   15'd0, 8'h01, 8'h00};
        v2[7] = '{BUS_READ_PROG,  15'd2, 8'h00, 8'h00};

        // ---- session 1 ----
        #2;
        do_reset(1'b1);
        load_byte(8'h11, 1'b0);
        load_byte(8'h22, 1'b0);
        load_byte(8'h33, 1'b1);
        check("run_in_term",        {31'h0, run}, 32'h0);
        check("load_ready_in_term", {31'h0, load_ready}, 32'h0);
        @(posedge clock);
        #1;
        check("run_after_term", {31'h0, run}, 32'h1);

        for (int i = 0; i < 9; i++) do_op(v1[i].op, v1[i].addr, v1[i].wdata, v1[i].exp);

        // In FIFO fill to full, extra byte dropped, drain in order.
        in_valid = 1'b1;
        for (int i = 0; i < FD; i++) begin
            in_data = 8'hA0 + 8'(i);
            @(posedge clock);
            #1;
        end
        check("in_full_ready", {31'h0, in_ready}, 32'h0);
        in_data = 8'hFF;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < FD; i++) do_op(BUS_READ_IO, 15'd0, 8'h00, 8'hA0 + 8'(i));
        bus_op = BUS_READ_IO;
        #1;
        check("in_empty_stall", {31'h0, cpu_enable}, 32'h0);

        // ",." with empty input: stall, then a single pushed byte feeds read and echo.
        @(posedge clock);
        #1;
        check("in_empty_stall_hold", {31'h0, cpu_enable}, 32'h0);
        in_valid = 1'b1;
        in_data = 8'h41;
        #1;
        check("in_no_bypass", {31'h0, cpu_enable}, 32'h0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        do_op(BUS_READ_IO, 15'd0, 8'h00, 8'h41);
        out_ready = 1'b1;
        base = out_seen;
        do_op(BUS_WRITE_IO, 15'd0, 8'h41, 8'h00);
        repeat (3) @(posedge clock);
        #1;
        check("echo_out_count", out_seen - base, 1);

        // "........." with out_ready low: fill out FIFO, stall, release.
        out_ready = 1'b0;
        base = out_seen;
        for (int i = 0; i < FD; i++) do_op(BUS_WRITE_IO, 15'd0, 8'h10 + 8'(i), 8'h00);
        bus_op = BUS_WRITE_IO;
        bus_wdata = 8'h14;
        #1;
        check("out_full_stall", {31'h0, cpu_enable}, 32'h0);
        check("out_full_valid", {31'h0, out_valid}, 32'h1);
        @(posedge clock);
        #1;
        check("out_full_stall_hold", {31'h0, cpu_enable}, 32'h0);
        out_ready = 1'b1;
        #1;
        check("out_full_pop_stall", {31'h0, cpu_enable}, 32'h0);
        for (int i = FD; i < 9; i++) do_op(BUS_WRITE_IO, 15'd0, 8'h10 + 8'(i), 8'h00);
        n = 0;
        while ((oq.size() != 0 || out_valid) && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("out_drain_left", oq.size(), 0);
        check("out_drain_count", out_seen - base, 9);

        // ---- session 2: reset mid-run, reload "+." ----
        do_reset(1'b0);
        load_byte(8'h2B, 1'b0);
        load_byte(8'h2E, 1'b1);
        check("run_in_term2", {31'h0, run}, 32'h0);
        @(posedge clock);
        #1;
        check("run_after_term2", {31'h0, run}, 32'h1);
        out_ready = 1'b1;
        base = out_seen;
        for (int i = 0; i < 8; i++) do_op(v2[i].op, v2[i].addr, v2[i].wdata, v2[i].exp);
        repeat (3) @(posedge clock);
        #1;
        check("prog_out_count", out_seen - base, 1);
        check("prog_out_left", oq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
